vram_arbiter: RTL and testbench

- Owns the single-port 12-bit pixel RAM between the VGA scanout engine and the game renderer.
- VGA reads get absolute priority: every cycle with vga_rdn low drives the RAM address from vga_row/vga_col.
- Renderer pixel writes are buffered in a small FIFO and drained only in cycles where VGA is not reading (blanking).
- A clear sequencer fills the whole visible frame with one colour, again using only those free cycles.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/pix_fifo.sv | 59 +++++
 rtl/vram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared pixel/VRAM definitions for the VGA subsystem.
// Provides pixel and address widths, default frame geometry, the write-FIFO
// entry layout, the arbiter state encoding and the pixel_addr() helper.
package vga_pkg;

    localparam int unsigned DATA_W         = 12;   // bbbb_gggg_rrrr
    localparam int unsigned VGA_ROWS       = 480;
    localparam int unsigned VGA_COLS       = 640;
    localparam int unsigned ROW_W          = 9;
    localparam int unsigned COL_W          = 10;
    localparam int unsigned ADDR_W         = ROW_W + COL_W;
    localparam int unsigned DEF_FIFO_DEPTH = 8;
    localparam int unsigned DROP_W         = 8;

    // One buffered renderer write
    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] data;
    } pix_entry_t;

    localparam int unsigned ENTRY_W = $bits(pix_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } arb_state_t;

    // RAM address is the plain {row, col} concatenation
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous FIFO buffering renderer pixel writes.
// Ports: clk/rst (async, active-high); push/din write side; pop/dout read
// side with dout showing the head entry combinationally; full/empty flags.
// Push while full and pop while empty are ignored.
module pix_fifo #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    // Pointers carry one extra wrap bit to tell full from empty
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; occupancy is defined by the pointers
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port pixel RAM arbiter between VGA scanout and the renderer.
// Ports: clk/rst (async, active-high); vga_row/col/rdn scanout request and
// vga_din read data; wr_valid/ready/row/col/data renderer writes (buffered);
// clr_start/color/busy/done full-frame clear; drop_cnt out-of-range writes;
// ram_addr/we/wdata/q RAM port.
// VGA reads always win; FIFO drain and the clear sequencer use only cycles
// where vga_rdn is high.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned ROWS       = VGA_ROWS,
    parameter int unsigned COLS       = VGA_COLS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROW_W-1:0]  vga_row,
    input  logic [COL_W-1:0]  vga_col,
    input  logic              vga_rdn,
    output logic [DATA_W-1:0] vga_din,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [DROP_W-1:0] drop_cnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q
);

    arb_state_t        state_q, state_d;
    logic [ROW_W-1:0]  crow_q, crow_d;
    logic [COL_W-1:0]  ccol_q, ccol_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              done_q, done_d;

    pix_entry_t push_entry;
    pix_entry_t head;
    logic       fifo_full, fifo_empty;
    logic       accept_c, in_range_c, push_c, pop_c, clr_wr_c, last_pix_c;

    assign accept_c   = wr_valid && !fifo_full;
    assign in_range_c = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
    // Out-of-range writes are accepted (handshake completes) but never stored
    assign push_c     = accept_c && in_range_c;
    assign pop_c      = vga_rdn && !fifo_empty &&
                        ((state_q == ST_IDLE) || (state_q == ST_DRAIN));
    assign clr_wr_c   = vga_rdn && (state_q == ST_CLEAR);
    assign last_pix_c = (crow_q == ROW_W'(ROWS - 1)) && (ccol_q == COL_W'(COLS - 1));

    assign push_entry.row  = wr_row;
    assign push_entry.col  = wr_col;
    assign push_entry.data = wr_data;

    pix_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .din   (push_entry),
        .pop   (pop_c),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // RAM port mux: scanout address by default, a write source only when free
    always_comb begin
        ram_addr  = pixel_addr(vga_row, vga_col);
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (clr_wr_c) begin
            ram_addr  = pixel_addr(crow_q, ccol_q);
            ram_we    = 1'b1;
            ram_wdata = color_q;
        end else if (pop_c) begin
            ram_addr  = pixel_addr(head.row, head.col);
            ram_we    = 1'b1;
            ram_wdata = head.data;
        end
    end

    // Next-state: clear sequencer FSM plus drop counter
    always_comb begin
        state_d = state_q;
        crow_d  = crow_q;
        ccol_d  = ccol_q;
        color_d = color_q;
        drop_d  = drop_q;
        done_d  = 1'b0;

        if (accept_c && !in_range_c && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_DRAIN;
                    color_d = clr_color;
                    crow_d  = '0;
                    ccol_d  = '0;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clr_wr_c) begin
                    if (last_pix_c) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        crow_d  = '0;
                        ccol_d  = '0;
                    end else if (ccol_q == COL_W'(COLS - 1)) begin
                        ccol_d = '0;
                        crow_d = crow_q + ROW_W'(1);
                    end else begin
                        ccol_d = ccol_q + COL_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            crow_q  <= '0;
            ccol_q  <= '0;
            color_q <= '0;
            drop_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crow_q  <= crow_d;
            ccol_q  <= ccol_d;
            color_q <= color_d;
            drop_q  <= drop_d;
            done_q  <= done_d;
        end
    end

    assign vga_din  = ram_q;
    assign wr_ready = !fifo_full;
    assign clr_busy = (state_q != ST_IDLE);
    assign clr_done = done_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter on a reduced 48x64 frame.
// Inputs change 1 time unit after the rising edge; outputs are observed on
// the falling edge of the same cycle.
module tb_vram_arbiter;

    localparam int unsigned T_ROWS = 48;
    localparam int unsigned T_COLS = 64;
    localparam int unsigned T_PIX  = T_ROWS * T_COLS;

    logic        clk;
    logic        rst;
    logic [8:0]  vga_row;
    logic [9:0]  vga_col;
    logic        vga_rdn;
    logic [11:0] vga_din;
    logic        wr_valid;
    logic        wr_ready;
    logic [8:0]  wr_row;
    logic [9:0]  wr_col;
    logic [11:0] wr_data;
    logic        clr_start;
    logic [11:0] clr_color;
    logic        clr_busy;
    logic        clr_done;
    logic [7:0]  drop_cnt;
    logic [18:0] ram_addr;
    logic        ram_we;
    logic [11:0] ram_wdata;
    logic [11:0] ram_q;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic covered [T_PIX];

    vram_arbiter #(
        .ROWS       (T_ROWS),
        .COLS       (T_COLS),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vga_row   (vga_row),
        .vga_col   (vga_col),
        .vga_rdn   (vga_rdn),
        .vga_din   (vga_din),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .drop_cnt  (drop_cnt),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_q     (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vga_rdn = 1'b0; vga_row = '0; vga_col = '0;
        wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        clr_start = 1'b0; clr_color = '0; ram_q = '0;
        @(negedge clk);
        vec_cnt++; if (wr_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_wr_ready got %b exp 1", wr_ready); end
        vec_cnt++; if (clr_busy !== 1'b0) begin err_cnt++; $display("FAIL rst_clr_busy got %b exp 0", clr_busy); end
        vec_cnt++; if (clr_done !== 1'b0) begin err_cnt++; $display("FAIL rst_clr_done got %b exp 0", clr_done); end
        vec_cnt++; if (drop_cnt !== 8'd0) begin err_cnt++; $display("FAIL rst_drop_cnt got %0d exp 0", drop_cnt); end
        vec_cnt++; if (ram_we !== 1'b0) begin err_cnt++; $display("FAIL rst_ram_we got %b exp 0", ram_we); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_vga_read();
        logic [18:0] exp_a;
        exp_a = {9'd5, 10'd7};
        vga_rdn = 1'b0; vga_row = 9'd5; vga_col = 10'd7; ram_q = 12'h123;
        @(negedge clk);
        vec_cnt++; if (ram_addr !== exp_a) begin err_cnt++; $display("FAIL vga_addr got %h exp %h", ram_addr, exp_a); end
        vec_cnt++; if (vga_din !== 12'h123) begin err_cnt++; $display("FAIL vga_din got %h exp 123", vga_din); end
        vec_cnt++; if (ram_we !== 1'b0) begin err_cnt++; $display("FAIL vga_read_we got %b exp 0", ram_we); end
        next_cycle();
    endtask

    task automatic test_hold_write();
        logic [18:0] exp_a;
        exp_a = {9'd10, 10'd20};
        vga_rdn = 1'b0;
        wr_valid = 1'b1; wr_row = 9'd10; wr_col = 10'd20; wr_data = 12'hABC;
        @(negedge clk);
        vec_cnt++; if (ram_we !== 1'b0) begin err_cnt++; $display("FAIL hold_we_push got %b exp 0", ram_we); end
        next_cycle();
        wr_valid = 1'b0;
        @(negedge clk);
        vec_cnt++; if (ram_we !== 1'b0) begin err_cnt++; $display("FAIL hold_we_busy got %b exp 0", ram_we); end
        next_cycle();
        vga_rdn = 1'b1;
        @(negedge clk);
        vec_cnt++; if (ram_we !== 1'b1) begin err_cnt++; $display("FAIL hold_we_free got %b exp 1", ram_we); end
        vec_cnt++; if (ram_addr !== exp_a) begin err_cnt++; $display("FAIL hold_addr got %h exp %h", ram_addr, exp_a); end
        vec_cnt++; if (ram_wdata !== 12'hABC) begin err_cnt++; $display("FAIL hold_wdata got %h exp abc", ram_wdata); end
        next_cycle();
        @(negedge clk);
        vec_cnt++; if (ram_we !== 1'b0) begin err_cnt++; $display("FAIL hold_we_after got %b exp 0", ram_we); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [18:0] exp_a;
        logic [11:0] exp_d;
        vga_rdn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_row = 9'(i + 1); wr_col = 10'(2 * i + 3); wr_data = 12'(256 + i);
            @(negedge clk);
            vec_cnt++; if (wr_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready_%0d got %b exp 1", i, wr_ready); end
            next_cycle();
        end
        // Full: this request must be refused
        wr_valid = 1'b1; wr_row = 9'd30; wr_col = 10'd30; wr_data = 12'hFFF;
        @(negedge clk);
        vec_cnt++; if (wr_ready !== 1'b0) begin err_cnt++; $display("FAIL b2b_full got %b exp 0", wr_ready); end
        next_cycle();
        wr_valid = 1'b0; vga_rdn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_a = {9'(i + 1), 10'(2 * i + 3)};
            exp_d = 12'(256 + i);
            @(negedge clk);
            vec_cnt++;
            if (ram_we !== 1'b1 || ram_addr !== exp_a || ram_wdata !== exp_d) begin
                err_cnt++;
                $display("FAIL b2b_pop_%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h", i, ram_we, ram_addr, ram_wdata, exp_a, exp_d);
            end
            if (i >= 1) begin
                vec_cnt++; if (wr_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready_pop_%0d got %b exp 1", i, wr_ready); end
            end
            next_cycle();
        end
        @(negedge clk);
        vec_cnt++; if (ram_we !== 1'b0) begin err_cnt++; $display("FAIL b2b_empty_we got %b exp 0", ram_we); end
        next_cycle();
        // Push/pop overlap; a write never reaches RAM in its own push cycle
        wr_valid = 1'b1; wr_row = 9'd3; wr_col = 10'd4; wr_data = 12'h345;
        @(negedge clk);
        vec_cnt++; if (ram_we !== 1'b0) begin err_cnt++; $display("FAIL pp_first_we got %b exp 0", ram_we); end
        next_cycle();
        wr_row = 9'd6; wr_col = 10'd7; wr_data = 12'h678;
        exp_a = {9'd3, 10'd4};
        @(negedge clk);
        vec_cnt++;
        if (ram_we !== 1'b1 || ram_addr !== exp_a || ram_wdata !== 12'h345) begin
            err_cnt++; $display("FAIL pp_pop0 got we=%b a=%h d=%h exp we=1 a=%h d=345", ram_we, ram_addr, ram_wdata, exp_a);
        end
        next_cycle();
        wr_valid = 1'b0;
        exp_a = {9'd6, 10'd7};
        @(negedge clk);
        vec_cnt++;
        if (ram_we !== 1'b1 || ram_addr !== exp_a || ram_wdata !== 12'h678) begin
            err_cnt++; $display("FAIL pp_pop1 got we=%b a=%h d=%h exp we=1 a=%h d=678", ram_we, ram_addr, ram_wdata, exp_a);
        end
        next_cycle();
        @(negedge clk);
        vec_cnt++; if (ram_we !== 1'b0) begin err_cnt++; $display("FAIL pp_end_we got %b exp 0", ram_we); end
        next_cycle();
    endtask

    task automatic test_drop();
        logic [18:0] exp_a;
        int stray;
        vga_rdn = 1'b1;
        wr_valid = 1'b1; wr_row = 9'd48; wr_col = 10'd0; wr_data = 12'hAAA;
        @(negedge clk);
        vec_cnt++; if (ram_we !== 1'b0) begin err_cnt++; $display("FAIL drop_row_we got %b exp 0", ram_we); end
        next_cycle();
        wr_row = 9'd0; wr_col = 10'd64; wr_data = 12'hBBB;
        @(negedge clk);
        vec_cnt++; if (ram_we !== 1'b0) begin err_cnt++; $display("FAIL drop_col_we got %b exp 0", ram_we); end
        next_cycle();
        wr_row = 9'd47; wr_col = 10'd63; wr_data = 12'hDEF;
        @(negedge clk);
        vec_cnt++; if (ram_we !== 1'b0) begin err_cnt++; $display("FAIL drop_none_stored got %b exp 0", ram_we); end
        vec_cnt++; if (drop_cnt !== 8'd2) begin err_cnt++; $display("FAIL drop_cnt2 got %0d exp 2", drop_cnt); end
        next_cycle();
        wr_valid = 1'b0;
        exp_a = {9'd47, 10'd63};
        @(negedge clk);
        vec_cnt++;
        if (ram_we !== 1'b1 || ram_addr !== exp_a || ram_wdata !== 12'hDEF) begin
            err_cnt++; $display("FAIL drop_corner got we=%b a=%h d=%h exp we=1 a=%h d=def", ram_we, ram_addr, ram_wdata, exp_a);
        end
        next_cycle();
        stray = 0;
        for (int k = 0; k < 300; k++) begin
            wr_valid = 1'b1;
            if (k % 2 == 0) begin
                wr_row = 9'(48 + (k % 400)); wr_col = 10'(k % 64);
            end else begin
                wr_row = 9'(k % 48); wr_col = 10'(64 + (k % 900));
            end
            wr_data = 12'(k);
            @(negedge clk);
            if (ram_we !== 1'b0) stray++;
            if (k == 100) begin
                vec_cnt++; if (drop_cnt !== 8'd102) begin err_cnt++; $display("FAIL drop_cnt102 got %0d exp 102", drop_cnt); end
            end
            next_cycle();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        vec_cnt++; if (drop_cnt !== 8'd255) begin err_cnt++; $display("FAIL drop_sat got %0d exp 255", drop_cnt); end
        vec_cnt++; if (stray !== 0) begin err_cnt++; $display("FAIL drop_stray_we got %0d exp 0", stray); end
        next_cycle();
    endtask

    task automatic test_clear();
        int fifo_seen, fifo_err, clr_cnt, dup, bad_data, bad_we, done_pulses, done_cyc, uncovered;
        logic prev_final, poked, finished, seq_ok;
        int idx;
        logic [18:0] exp_a;
        fifo_seen = 0; fifo_err = 0; clr_cnt = 0; dup = 0; bad_data = 0; bad_we = 0;
        done_pulses = 0; done_cyc = 0; prev_final = 1'b0; poked = 1'b0; finished = 1'b0; seq_ok = 1'b1;
        for (int p = 0; p < int'(T_PIX); p++) covered[p] = 1'b0;
        vga_rdn = 1'b0;
        for (int j = 0; j < 3; j++) begin
            wr_valid = 1'b1; wr_row = 9'(j + 1); wr_col = 10'(j + 1); wr_data = 12'(273 * (j + 1));
            next_cycle();
        end
        wr_valid = 1'b0; clr_start = 1'b1; clr_color = 12'h00F;
        @(negedge clk);
        vec_cnt++; if (clr_busy !== 1'b0) begin err_cnt++; $display("FAIL clr_busy_pre got %b exp 0", clr_busy); end
        next_cycle();
        clr_start = 1'b0; clr_color = 12'h000;
        for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
            vga_rdn = ((cyc % 5) != 4);
            if (clr_cnt == 1000 && !poked) begin
                poked = 1'b1; clr_start = 1'b1; clr_color = 12'hF00;
            end else begin
                clr_start = 1'b0; clr_color = 12'h000;
            end
            @(negedge clk);
            if (cyc == 0) begin
                vec_cnt++; if (clr_busy !== 1'b1) begin err_cnt++; $display("FAIL clr_busy_start got %b exp 1", clr_busy); end
            end
            if (!vga_rdn && ram_we) bad_we++;
            if (clr_done === 1'b1) begin
                done_pulses++; done_cyc = cyc;
                if (!prev_final) seq_ok = 1'b0;
            end
            prev_final = ram_we && (ram_addr == {9'd47, 10'd63});
            if (ram_we === 1'b1) begin
                if (fifo_seen < 3) begin
                    exp_a = {9'(fifo_seen + 1), 10'(fifo_seen + 1)};
                    if (ram_addr !== exp_a || ram_wdata !== 12'(273 * (fifo_seen + 1))) fifo_err++;
                    fifo_seen++;
                end else begin
                    if (ram_wdata !== 12'h00F) bad_data++;
                    if (32'(ram_addr[18:10]) >= T_ROWS || 32'(ram_addr[9:0]) >= T_COLS) begin
                        bad_data++;
                    end else begin
                        idx = 32'(ram_addr[18:10]) * T_COLS + 32'(ram_addr[9:0]);
                        if (covered[idx]) dup++;
                        covered[idx] = 1'b1;
                    end
                    clr_cnt++;
                end
            end
            if (done_pulses > 0 && cyc >= done_cyc + 3) finished = 1'b1;
            next_cycle();
        end
        clr_start = 1'b0;
        uncovered = 0;
        for (int p = 0; p < int'(T_PIX); p++) if (!covered[p]) uncovered++;
        vec_cnt++; if (finished !== 1'b1) begin err_cnt++; $display("FAIL clr_timeout got done_pulses=%0d exp 1 within budget", done_pulses); end
        vec_cnt++; if (fifo_seen !== 3 || fifo_err !== 0) begin err_cnt++; $display("FAIL clr_fifo_first got seen=%0d err=%0d exp 3/0", fifo_seen, fifo_err); end
        vec_cnt++; if (clr_cnt !== int'(T_PIX)) begin err_cnt++; $display("FAIL clr_count got %0d exp %0d", clr_cnt, T_PIX); end
        vec_cnt++; if (dup !== 0 || uncovered !== 0 || bad_data !== 0) begin err_cnt++; $display("FAIL clr_cover got dup=%0d uncov=%0d bad=%0d exp 0/0/0", dup, uncovered, bad_data); end
        vec_cnt++; if (bad_we !== 0) begin err_cnt++; $display("FAIL clr_we_during_read got %0d exp 0", bad_we); end
        vec_cnt++; if (done_pulses !== 1 || seq_ok !== 1'b1) begin err_cnt++; $display("FAIL clr_done_pulse got n=%0d after_last=%b exp 1/1", done_pulses, seq_ok); end
        @(negedge clk);
        vec_cnt++; if (clr_busy !== 1'b0) begin err_cnt++; $display("FAIL clr_busy_after got %b exp 0", clr_busy); end
        next_cycle();
    endtask

    task automatic test_reset_abort();
        logic found;
        int c;
        vga_rdn = 1'b1; clr_start = 1'b1; clr_color = 12'hAAA;
        next_cycle();
        clr_start = 1'b0;
        found = 1'b0;
        for (c = 0; c < 3000 && !found; c++) begin
            @(negedge clk);
            if (ram_we === 1'b1 && ram_addr[18:10] == 9'd20) found = 1'b1;
            next_cycle();
        end
        vec_cnt++; if (found !== 1'b1) begin err_cnt++; $display("FAIL abort_reach_row20 got %b exp 1", found); end
        rst = 1'b1;
        @(negedge clk);
        vec_cnt++; if (clr_busy !== 1'b0) begin err_cnt++; $display("FAIL abort_busy got %b exp 0", clr_busy); end
        vec_cnt++; if (ram_we !== 1'b0) begin err_cnt++; $display("FAIL abort_we got %b exp 0", ram_we); end
        vec_cnt++; if (clr_done !== 1'b0) begin err_cnt++; $display("FAIL abort_done got %b exp 0", clr_done); end
        vec_cnt++; if (drop_cnt !== 8'd0) begin err_cnt++; $display("FAIL abort_drop got %0d exp 0", drop_cnt); end
        next_cycle();
        rst = 1'b0; clr_start = 1'b1; clr_color = 12'h0F0;
        @(negedge clk);
        vec_cnt++; if (clr_done !== 1'b0 || ram_we !== 1'b0) begin err_cnt++; $display("FAIL restart_idle got done=%b we=%b exp 0/0", clr_done, ram_we); end
        next_cycle();
        clr_start = 1'b0; clr_color = 12'h000;
        @(negedge clk);
        vec_cnt++; if (clr_busy !== 1'b1) begin err_cnt++; $display("FAIL restart_busy got %b exp 1", clr_busy); end
        found = 1'b0;
        for (c = 0; c < 10 && !found; c++) begin
            if (c > 0) @(negedge clk);
            if (ram_we === 1'b1) begin
                found = 1'b1;
                vec_cnt++;
                if (ram_addr !== 19'd0 || ram_wdata !== 12'h0F0) begin
                    err_cnt++; $display("FAIL restart_origin got a=%h d=%h exp a=0 d=0f0", ram_addr, ram_wdata);
                end
            end
            next_cycle();
        end
        vec_cnt++; if (found !== 1'b1) begin err_cnt++; $display("FAIL restart_timeout got %b exp 1", found); end
        rst = 1'b1;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_vga_read();
        test_hold_write();
        test_back_to_back();
        test_drop();
        test_clear();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
